mul_add_seq: RTL and testbench

Sequential shift-add multiply-accumulate that rebuilds a dividend from a divider result as dividend = quotient × divisor + remainder. It is the inverse companion of the restoring divider pipeline. It sits after the divider output for self-check and for back-conversion, and uses the same N/M width convention. It processes one quotient bit per clock, LSB first, under a start/busy/ready handshake.

---
 rtl/mul_add_seq_if.sv | 29 ++
 rtl/mul_add_seq.sv | 103 ++++++++++
 tb/tb_mul_add_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_add_seq_if.sv
// Operand/result bundle for mul_add_seq: start request with q/d/r operands,
// busy/rdy status and the rebuilt dividend with its flags.
interface mul_add_seq_if #(
    parameter int N = 5,
    parameter int M = 3
);
    localparam int Q = N - M + 1;

    logic         en;
    logic [Q-1:0] quotient;
    logic [M-1:0] divisor;
    logic [M-1:0] remainder;
    logic         busy;
    logic         rdy;
    logic [N:0]   dividend;
    logic         ovf;
    logic         rem_ok;
    logic         div0;

    modport master (
        output en, quotient, divisor, remainder,
        input  busy, rdy, dividend, ovf, rem_ok, div0
    );

    modport slave (
        input  en, quotient, divisor, remainder,
        output busy, rdy, dividend, ovf, rem_ok, div0
    );
endinterface

// File: rtl/mul_add_seq.sv
// Shift-add multiply-accumulate rebuilding dividend = quotient*divisor + remainder,
// one quotient bit per clock, LSB first, under a start/busy/rdy handshake.
module mul_add_seq #(
    parameter int N = 5,
    parameter int M = 3
) (
    input  logic           clk,
    input  logic           rst,
    mul_add_seq_if.slave   bus
);
    localparam int Q  = N - M + 1;
    localparam int W  = N + 1;
    localparam int CW = $clog2(Q + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [Q-1:0]  mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, rdy_d;
    logic [W-1:0]  dividend_q, dividend_d;
    logic          ovf_q, ovf_d;
    logic          rem_ok_q, rem_ok_d;
    logic          div0_q, div0_d;
    logic [W-1:0]  acc_sum;

    // Max result is below 2^W, so the accumulate never carries out of W bits.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        rdy_d      = 1'b0;
        dividend_d = dividend_q;
        ovf_d      = ovf_q;
        rem_ok_d   = rem_ok_q;
        div0_d     = div0_q;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    acc_d    = W'(bus.remainder);
                    mcand_d  = W'(bus.divisor);
                    mplier_d = bus.quotient;
                    cnt_d    = '0;
                    rem_ok_d = (bus.remainder < bus.divisor);
                    div0_d   = (bus.divisor == '0);
                    state_d  = RUN;
                end
            end
            default: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(Q - 1)) begin
                    dividend_d = acc_sum;
                    ovf_d      = acc_sum[N];
                    rdy_d      = 1'b1;
                    state_d    = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
            dividend_q <= '0;
            ovf_q      <= 1'b0;
            rem_ok_q   <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
            dividend_q <= dividend_d;
            ovf_q      <= ovf_d;
            rem_ok_q   <= rem_ok_d;
            div0_q     <= div0_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.rdy      = rdy_q;
    assign bus.dividend = dividend_q;
    assign bus.ovf      = ovf_q;
    assign bus.rem_ok   = rem_ok_q;
    assign bus.div0     = div0_q;
endmodule

// File: tb/tb_mul_add_seq.sv
// Scoreboard bench for mul_add_seq: directed handshake cases on N=5/M=3,
// exhaustive N=5/M=3 and random N=8/M=4 operands against q*d+r.
module tb_mul_add_seq;
    typedef struct {
        int   dv;
        logic ovf;
        logic rok;
        logic d0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    mul_add_seq_if #(.N(5), .M(3)) a_if ();
    mul_add_seq_if #(.N(8), .M(4)) b_if ();

    mul_add_seq #(.N(5), .M(3)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
    mul_add_seq #(.N(8), .M(4)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic exp_t model(input int q, input int d, input int r, input int n);
        exp_t e;
        e.dv  = q * d + r;
        e.ovf = (e.dv >= (1 << n));
        e.rok = (r < d);
        e.d0  = (d == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && a_if.rdy) begin
            if (q_a.size() == 0) check("a_spurious_rdy", 1, 0);
            else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_dividend", 32'(a_if.dividend), e.dv);
                check("a_ovf", 32'(a_if.ovf), 32'(e.ovf));
                check("a_rem_ok", 32'(a_if.rem_ok), 32'(e.rok));
                check("a_div0", 32'(a_if.div0), 32'(e.d0));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_if.rdy) begin
            if (q_b.size() == 0) check("b_spurious_rdy", 1, 0);
            else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_dividend", 32'(b_if.dividend), e.dv);
                check("b_ovf", 32'(b_if.ovf), 32'(e.ovf));
                check("b_rem_ok", 32'(b_if.rem_ok), 32'(e.rok));
                check("b_div0", 32'(b_if.div0), 32'(e.d0));
            end
        end
    end

    // Waits for idle, presents one start for one edge; returns on the negedge after acceptance.
    task automatic drive_a(input int q, input int d, input int r);
        int unsigned budget = 0;
        while (a_if.busy && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (a_if.busy) check("a_idle_timeout", 1, 0);
        a_if.en        = 1'b1;
        a_if.quotient  = 3'(q);
        a_if.divisor   = 3'(d);
        a_if.remainder = 3'(r);
        q_a.push_back(model(q, d, r, 5));
        @(negedge clk);
        a_if.en = 1'b0;
    endtask

    task automatic drive_b(input int q, input int d, input int r);
        int unsigned budget = 0;
        while (b_if.busy && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (b_if.busy) check("b_idle_timeout", 1, 0);
        b_if.en        = 1'b1;
        b_if.quotient  = 5'(q);
        b_if.divisor   = 4'(d);
        b_if.remainder = 4'(r);
        q_b.push_back(model(q, d, r, 8));
        @(negedge clk);
        b_if.en = 1'b0;
    endtask

    // Directed op with latency, capture-at-accept and one-cycle rdy checks.
    task automatic run_a(input int q, input int d, input int r);
        int lat = 0;
        int dv;
        drive_a(q, d, r);
        check("accept_busy", 32'(a_if.busy), 1);
        check("accept_rem_ok", 32'(a_if.rem_ok), 32'(r < d));
        check("accept_div0", 32'(a_if.div0), 32'(d == 0));
        while (!a_if.rdy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
        check("busy_at_rdy", 32'(a_if.busy), 0);
        dv = int'(a_if.dividend);
        @(negedge clk);
        check("rdy_one_cycle", 32'(a_if.rdy), 0);
        check("dividend_hold", 32'(a_if.dividend), dv);
    endtask

    initial begin
        int rdy_cnt;
        a_if.en = 1'b0; a_if.quotient = '0; a_if.divisor = '0; a_if.remainder = '0;
        b_if.en = 1'b0; b_if.quotient = '0; b_if.divisor = '0; b_if.remainder = '0;

        @(negedge clk);
        check("rst_busy", 32'(a_if.busy), 0);
        check("rst_rdy", 32'(a_if.rdy), 0);
        check("rst_dividend", 32'(a_if.dividend), 0);
        check("rst_flags", {29'd0, a_if.ovf, a_if.rem_ok, a_if.div0}, 0);
        check("rst_b_dividend", 32'(b_if.dividend), 0);
        rst = 1'b0;
        @(negedge clk);

        run_a(6, 4, 3);
        run_a(7, 7, 6);
        run_a(2, 3, 5);
        run_a(5, 0, 2);

        // Busy-time starts, including the completing edge, must be dropped.
        drive_a(3, 5, 1);
        rdy_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            a_if.en = 1'b1;
            a_if.quotient = 3'(7 - k); a_if.divisor = 3'(k + 1); a_if.remainder = 3'(k);
            @(negedge clk);
            if (a_if.rdy) rdy_cnt++;
        end
        a_if.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (a_if.rdy) rdy_cnt++;
            check("ignored_no_start", 32'(a_if.busy), 0);
        end
        check("ignored_rdy_count", rdy_cnt, 1);

        // en held high: accepts at t0, t0+4, t0+8.
        a_if.en = 1'b1;
        a_if.quotient = 3'd2; a_if.divisor = 3'd3; a_if.remainder = 3'd1;
        for (int k = 0; k < 3; k++) q_a.push_back(model(2, 3, 1, 5));
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("cont_rdy", 32'(a_if.rdy), 32'(i == 3 || i == 7 || i == 11));
            check("cont_busy", 32'(a_if.busy), 32'(!(i == 3 || i == 7 || i >= 11)));
            if (i == 8) a_if.en = 1'b0;
        end

        // Asynchronous reset one cycle into RUN.
        a_if.en = 1'b1; a_if.quotient = 3'd7; a_if.divisor = 3'd7; a_if.remainder = 3'd6;
        @(negedge clk);
        a_if.en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(a_if.busy), 0);
        check("arst_dividend", 32'(a_if.dividend), 0);
        check("arst_flags", {29'd0, a_if.ovf, a_if.rem_ok, a_if.div0}, 0);
        @(negedge clk);
        rst = 1'b0;
        rdy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_if.rdy) rdy_cnt++;
        end
        check("arst_no_rdy", rdy_cnt, 0);
        run_a(1, 1, 0);

        fork
            begin
                for (int q = 0; q < 8; q++)
                    for (int d = 0; d < 8; d++)
                        for (int r = 0; r < 8; r++)
                            drive_a(q, d, r);
            end
            begin
                drive_b(31, 15, 15);
                drive_b(0, 0, 0);
                drive_b(31, 0, 15);
                for (int n = 0; n < 2000; n++)
                    drive_b(int'($urandom_range(31)), int'($urandom_range(15)),
                            int'($urandom_range(15)));
            end
        join

        repeat (10) @(negedge clk);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
